// File: rtl/tank_game_pkg.sv
// Shared tank-game constants: headings, coordinate width, screen bounds and tank geometry.
// Also holds the small coordinate helpers used by the bullet logic.
package tank_game_pkg;

    localparam int COORD_W = 10;

    typedef logic [COORD_W-1:0] coord_t;

    typedef enum logic [1:0] {
        DIR_UP    = 2'b00,
        DIR_DOWN  = 2'b01,
        DIR_LEFT  = 2'b10,
        DIR_RIGHT = 2'b11
    } dir_e;

    localparam coord_t SCREEN_X_MIN = 10'd3;
    localparam coord_t SCREEN_X_MAX = 10'd636;
    localparam coord_t SCREEN_Y_MIN = 10'd1;
    localparam coord_t SCREEN_Y_MAX = 10'd476;
    localparam int     TANK_SIZE    = 30;
    localparam int     MUZZLE_OFS   = 14;

    // Signed 12-bit intermediate coordinates never wrap, so clamping is exact.
    function automatic coord_t clamp_coord(input logic signed [11:0] v,
                                           input coord_t lo, input coord_t hi);
        if (v < $signed({2'b00, lo})) begin
            return lo;
        end else if (v > $signed({2'b00, hi})) begin
            return hi;
        end else begin
            return coord_t'(v[COORD_W-1:0]);
        end
    endfunction

    function automatic coord_t abs_diff(input coord_t a, input coord_t b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

    function automatic logic in_square(input coord_t px, input coord_t py,
                                       input coord_t tx, input coord_t ty,
                                       input logic [COORD_W:0] side);
        return ({1'b0, px} >= {1'b0, tx}) && ({1'b0, px} < ({1'b0, tx} + side)) &&
               ({1'b0, py} >= {1'b0, ty}) && ({1'b0, py} < ({1'b0, ty} + side));
    endfunction

endpackage

// File: rtl/bullet_slot.sv
// One bullet slot: spawns on strobe, moves one step per tick, dies on bound,
// foreign-tank hit or foreign-bullet near-hit, and reports which tank it died in.
module bullet_slot
    import tank_game_pkg::*;
#(
    parameter int     NT      = 5,
    parameter int     SELF    = 3,
    parameter int     NO      = 8,
    parameter int     SPEED   = 3,
    parameter int     TANK_SZ = TANK_SIZE,
    parameter int     HIT_R   = 2,
    parameter coord_t X_MIN   = SCREEN_X_MIN,
    parameter coord_t X_MAX   = SCREEN_X_MAX,
    parameter coord_t Y_MIN   = SCREEN_Y_MIN,
    parameter coord_t Y_MAX   = SCREEN_Y_MAX
) (
    input  logic                  clk_f,
    input  logic                  rst_n,
    input  logic                  own_alive,
    input  logic                  spawn,
    input  coord_t                spawn_x,
    input  coord_t                spawn_y,
    input  logic [1:0]            spawn_dir,
    input  logic [NT-1:0]         tank_exit,
    input  logic [COORD_W*NT-1:0] tank_x,
    input  logic [COORD_W*NT-1:0] tank_y,
    input  logic [NO-1:0]         other_exit,
    input  logic [COORD_W*NO-1:0] other_x,
    input  logic [COORD_W*NO-1:0] other_y,
    output logic                  slot_exit,
    output logic                  slot_new,
    output logic [1:0]            slot_dir,
    output coord_t                slot_x,
    output coord_t                slot_y,
    output logic [NT-1:0]         slot_hit
);

    localparam logic signed [11:0] SPD12 = $signed(12'(SPEED));
    localparam logic [COORD_W:0]   TSZ11 = 11'(TANK_SZ);
    localparam coord_t             HR    = coord_t'(HIT_R);

    logic          exit_r, new_r;
    logic [1:0]    dir_r;
    coord_t        x_r, y_r, move_x_s, move_y_s;
    logic [NT-1:0] hit_r, tank_hit_s;
    logic          bullet_hit_s, bound_s, kill_s;

    // Kill detection against screen bounds, live foreign tanks and live foreign bullets
    always_comb begin
        tank_hit_s   = '0;
        bullet_hit_s = 1'b0;
        for (int i = 0; i < NT; i++) begin
            if ((i != SELF) && tank_exit[i] &&
                in_square(x_r, y_r, tank_x[COORD_W*i +: COORD_W], tank_y[COORD_W*i +: COORD_W], TSZ11)) begin
                tank_hit_s[i] = 1'b1;
            end else begin
                tank_hit_s[i] = 1'b0;
            end
        end
        for (int j = 0; j < NO; j++) begin
            if (other_exit[j] && (abs_diff(x_r, other_x[COORD_W*j +: COORD_W]) < HR) &&
                (abs_diff(y_r, other_y[COORD_W*j +: COORD_W]) < HR)) begin
                bullet_hit_s = 1'b1;
            end else begin
                bullet_hit_s = bullet_hit_s;
            end
        end
        bound_s = (x_r == X_MIN) || (x_r == X_MAX) || (y_r == Y_MIN) || (y_r == Y_MAX);
        kill_s  = bound_s || (|tank_hit_s) || bullet_hit_s;
    end

    // One step along the heading; clamping lands exactly on the bound so next tick kills
    always_comb begin
        move_x_s = x_r;
        move_y_s = y_r;
        case (dir_r)
            DIR_UP:    move_y_s = clamp_coord($signed({2'b00, y_r}) - SPD12, Y_MIN, Y_MAX);
            DIR_DOWN:  move_y_s = clamp_coord($signed({2'b00, y_r}) + SPD12, Y_MIN, Y_MAX);
            DIR_LEFT:  move_x_s = clamp_coord($signed({2'b00, x_r}) - SPD12, X_MIN, X_MAX);
            DIR_RIGHT: move_x_s = clamp_coord($signed({2'b00, x_r}) + SPD12, X_MIN, X_MAX);
            default: begin
                move_x_s = x_r;
                move_y_s = y_r;
            end
        endcase
    end

    // Slot state: owner death clears, then spawn, then kill over move; idle holds position
    always_ff @(posedge clk_f or negedge rst_n) begin
        if (!rst_n) begin
            exit_r <= 1'b0;
            new_r  <= 1'b0;
            dir_r  <= 2'b00;
            x_r    <= 10'd0;
            y_r    <= 10'd0;
            hit_r  <= '0;
        end else if (!own_alive) begin
            exit_r <= 1'b0;
            new_r  <= 1'b0;
            hit_r  <= '0;
        end else if (spawn) begin
            exit_r <= 1'b1;
            new_r  <= 1'b1;
            dir_r  <= spawn_dir;
            x_r    <= spawn_x;
            y_r    <= spawn_y;
            hit_r  <= '0;
        end else if (exit_r && kill_s) begin
            exit_r <= 1'b0;
            new_r  <= 1'b0;
            hit_r  <= tank_hit_s;
        end else if (exit_r) begin
            x_r    <= move_x_s;
            y_r    <= move_y_s;
            new_r  <= 1'b0;
            hit_r  <= '0;
        end else begin
            new_r  <= 1'b0;
            hit_r  <= '0;
        end
    end

    assign slot_exit = exit_r;
    assign slot_new  = new_r;
    assign slot_dir  = dir_r;
    assign slot_x    = x_r;
    assign slot_y    = y_r;
    assign slot_hit  = hit_r;

endmodule

// File: rtl/tank_bullet_pool.sv
// Per-tank bullet pool: fire cooldown, lowest-free-slot allocation, muzzle spawn
// position and merge of per-slot tank hits into a single hit_tank pulse vector.
module tank_bullet_pool
    import tank_game_pkg::*;
#(
    parameter int     NB       = 2,
    parameter int     NT       = 5,
    parameter int     SELF     = 3,
    parameter int     NO       = 8,
    parameter int     SPEED    = 3,
    parameter int     TANK_SZ  = TANK_SIZE,
    parameter int     HIT_R    = 2,
    parameter int     COOLDOWN = 60,
    parameter coord_t X_MIN    = SCREEN_X_MIN,
    parameter coord_t X_MAX    = SCREEN_X_MAX,
    parameter coord_t Y_MIN    = SCREEN_Y_MIN,
    parameter coord_t Y_MAX    = SCREEN_Y_MAX
) (
    input  logic                  clk_f,
    input  logic                  rst_n,
    input  logic                  shoot,
    input  logic [NT-1:0]         tank_exit,
    input  logic [1:0]            tank_direction,
    input  logic [COORD_W*NT-1:0] tank_x,
    input  logic [COORD_W*NT-1:0] tank_y,
    input  logic [NO-1:0]         otherbullet_exit,
    input  logic [COORD_W*NO-1:0] other_bullet_x,
    input  logic [COORD_W*NO-1:0] other_bullet_y,
    output logic [NB-1:0]         bullet_exit,
    output logic [NB-1:0]         bullet_new,
    output logic [2*NB-1:0]       bullet_dir,
    output logic [COORD_W*NB-1:0] bullet_x,
    output logic [COORD_W*NB-1:0] bullet_y,
    output logic [NT-1:0]         hit_tank,
    output logic                  ready
);

    localparam int                CW    = $clog2(COOLDOWN + 1);
    localparam logic [CW-1:0]     CD_MAX = CW'(COOLDOWN);
    localparam logic signed [11:0] SPD12 = $signed(12'(SPEED));
    localparam logic signed [11:0] TSZ12 = $signed(12'(TANK_SZ));
    localparam logic signed [11:0] MUZ12 = $signed(12'(MUZZLE_OFS));

    logic [CW-1:0]     cooldown_r, cooldown_next_s;
    logic              ready_r, own_alive_s, free_any_s, accept_s;
    logic [NB-1:0]     free_oh_s, spawn_s;
    logic signed [11:0] own_x_s, own_y_s;
    coord_t            spawn_x_s, spawn_y_s;
    logic [NT-1:0]     slot_hit_s [NB];

    assign own_alive_s = tank_exit[SELF];
    assign own_x_s     = $signed({2'b00, tank_x[COORD_W*SELF +: COORD_W]});
    assign own_y_s     = $signed({2'b00, tank_y[COORD_W*SELF +: COORD_W]});

    // Lowest-index free slot as a one-hot
    always_comb begin
        free_oh_s  = '0;
        free_any_s = 1'b0;
        for (int i = 0; i < NB; i++) begin
            if (!bullet_exit[i] && !free_any_s) begin
                free_oh_s[i] = 1'b1;
                free_any_s   = 1'b1;
            end else begin
                free_oh_s[i] = 1'b0;
            end
        end
    end

    assign accept_s = shoot && ready_r && own_alive_s && free_any_s;
    assign spawn_s  = accept_s ? free_oh_s : '0;

    // Muzzle position for the current heading, clamped onto the playfield
    always_comb begin
        spawn_x_s = X_MIN;
        spawn_y_s = Y_MIN;
        case (tank_direction)
            DIR_UP: begin
                spawn_x_s = clamp_coord(own_x_s + MUZ12, X_MIN, X_MAX);
                spawn_y_s = clamp_coord(own_y_s - SPD12, Y_MIN, Y_MAX);
            end
            DIR_DOWN: begin
                spawn_x_s = clamp_coord(own_x_s + MUZ12, X_MIN, X_MAX);
                spawn_y_s = clamp_coord(own_y_s + TSZ12, Y_MIN, Y_MAX);
            end
            DIR_LEFT: begin
                spawn_x_s = clamp_coord(own_x_s - SPD12, X_MIN, X_MAX);
                spawn_y_s = clamp_coord(own_y_s + MUZ12, Y_MIN, Y_MAX);
            end
            DIR_RIGHT: begin
                spawn_x_s = clamp_coord(own_x_s + TSZ12, X_MIN, X_MAX);
                spawn_y_s = clamp_coord(own_y_s + MUZ12, Y_MIN, Y_MAX);
            end
            default: begin
                spawn_x_s = X_MIN;
                spawn_y_s = Y_MIN;
            end
        endcase
    end

    // Saturating cooldown; an accepted shot restarts it
    always_comb begin
        if (accept_s) begin
            cooldown_next_s = '0;
        end else if (cooldown_r == CD_MAX) begin
            cooldown_next_s = CD_MAX;
        end else begin
            cooldown_next_s = cooldown_r + CW'(1);
        end
    end

    // Cooldown register with ready kept as its registered terminal-count flag
    always_ff @(posedge clk_f or negedge rst_n) begin
        if (!rst_n) begin
            cooldown_r <= '0;
            ready_r    <= 1'b0;
        end else begin
            cooldown_r <= cooldown_next_s;
            ready_r    <= (cooldown_next_s == CD_MAX);
        end
    end

    assign ready = ready_r;

    for (genvar g = 0; g < NB; g++) begin : g_slot
        bullet_slot #(
            .NT(NT), .SELF(SELF), .NO(NO), .SPEED(SPEED), .TANK_SZ(TANK_SZ), .HIT_R(HIT_R),
            .X_MIN(X_MIN), .X_MAX(X_MAX), .Y_MIN(Y_MIN), .Y_MAX(Y_MAX)
        ) u_slot (
            .clk_f     (clk_f),
            .rst_n     (rst_n),
            .own_alive (own_alive_s),
            .spawn     (spawn_s[g]),
            .spawn_x   (spawn_x_s),
            .spawn_y   (spawn_y_s),
            .spawn_dir (tank_direction),
            .tank_exit (tank_exit),
            .tank_x    (tank_x),
            .tank_y    (tank_y),
            .other_exit(otherbullet_exit),
            .other_x   (other_bullet_x),
            .other_y   (other_bullet_y),
            .slot_exit (bullet_exit[g]),
            .slot_new  (bullet_new[g]),
            .slot_dir  (bullet_dir[2*g +: 2]),
            .slot_x    (bullet_x[COORD_W*g +: COORD_W]),
            .slot_y    (bullet_y[COORD_W*g +: COORD_W]),
            .slot_hit  (slot_hit_s[g])
        );
    end

    // Any slot dying inside tank i flags tank i
    always_comb begin
        hit_tank = '0;
        for (int i = 0; i < NB; i++) begin
            hit_tank = hit_tank | slot_hit_s[i];
        end
    end

endmodule

// File: tb/tb_tank_bullet_pool.sv
// Directed bench for tank_bullet_pool: cooldown, allocation, movement, bounds,
// tank/bullet kills, owner death and asynchronous reset.
module tb_tank_bullet_pool;

    logic        clk_f = 1'b0;
    logic        rst_n = 1'b0;
    logic        shoot = 1'b0;
    logic [4:0]  tank_exit = 5'b01000;
    logic [1:0]  tank_direction = 2'b11;
    logic [49:0] tank_x = '0;
    logic [49:0] tank_y = '0;
    logic [7:0]  otherbullet_exit = '0;
    logic [79:0] other_bullet_x = '0;
    logic [79:0] other_bullet_y = '0;
    logic [1:0]  bullet_exit, bullet_new;
    logic [3:0]  bullet_dir;
    logic [19:0] bullet_x, bullet_y;
    logic [4:0]  hit_tank;
    logic        ready;

    int checks = 0;
    int failures = 0;

    tank_bullet_pool dut (
        .clk_f(clk_f), .rst_n(rst_n), .shoot(shoot), .tank_exit(tank_exit),
        .tank_direction(tank_direction), .tank_x(tank_x), .tank_y(tank_y),
        .otherbullet_exit(otherbullet_exit), .other_bullet_x(other_bullet_x),
        .other_bullet_y(other_bullet_y), .bullet_exit(bullet_exit), .bullet_new(bullet_new),
        .bullet_dir(bullet_dir), .bullet_x(bullet_x), .bullet_y(bullet_y),
        .hit_tank(hit_tank), .ready(ready)
    );

    always #5 clk_f = ~clk_f;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_f);
        #1;
    endtask

    task automatic set_tank(input int idx, input int x, input int y);
        tank_x[10*idx +: 10] = 10'(x);
        tank_y[10*idx +: 10] = 10'(y);
    endtask

    task automatic wait_ready(input int budget);
        int n = 0;
        while (!ready && n < budget) begin
            tick();
            n++;
        end
        check("wait_ready", 32'(ready), 32'd1);
    endtask

    task automatic fire();
        shoot = 1'b1;
        tick();
        shoot = 1'b0;
    endtask

    initial begin
        set_tank(3, 100, 200);
        repeat (2) @(posedge clk_f);
        #1;
        check("rst_exit", 32'(bullet_exit), 32'd0);
        check("rst_xy", 32'({bullet_x, bullet_y}), 32'd0);
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_hit", 32'(hit_tank), 32'd0);
        rst_n = 1'b1;

        // Cooldown reaches COOLDOWN after 60 ticks
        repeat (59) tick();
        check("ready_59", 32'(ready), 32'd0);
        tick();
        check("ready_60", 32'(ready), 32'd1);

        // Held shoot: first spawn, movement, second slot after cooldown
        shoot = 1'b1;
        tick();
        check("spawn0_exit", 32'(bullet_exit), 32'd1);
        check("spawn0_new", 32'(bullet_new), 32'd1);
        check("spawn0_x", 32'(bullet_x[9:0]), 32'd130);
        check("spawn0_y", 32'(bullet_y[9:0]), 32'd214);
        check("spawn0_dir", 32'(bullet_dir[1:0]), 32'd3);
        check("spawn0_ready", 32'(ready), 32'd0);
        tick();
        check("move0_x", 32'(bullet_x[9:0]), 32'd133);
        check("move0_new", 32'(bullet_new), 32'd0);
        repeat (59) tick();
        check("cd_ready", 32'(ready), 32'd1);
        check("cd_exit", 32'(bullet_exit), 32'd1);
        check("cd_x0", 32'(bullet_x[9:0]), 32'd310);
        tick();
        check("spawn1_exit", 32'(bullet_exit), 32'd3);
        check("spawn1_new", 32'(bullet_new), 32'd2);
        check("spawn1_x", 32'(bullet_x[19:10]), 32'd130);
        check("spawn1_x0", 32'(bullet_x[9:0]), 32'd313);
        repeat (61) tick();
        check("full_exit", 32'(bullet_exit), 32'd3);
        check("full_ready", 32'(ready), 32'd1);
        repeat (48) tick();
        check("xmax_kill_exit", 32'(bullet_exit), 32'd2);
        check("xmax_kill_x", 32'(bullet_x[9:0]), 32'd636);
        check("xmax_ready", 32'(ready), 32'd1);
        tick();
        check("reuse_exit", 32'(bullet_exit), 32'd3);
        check("reuse_new", 32'(bullet_new), 32'd1);
        check("reuse_x", 32'(bullet_x[9:0]), 32'd130);
        shoot = 1'b0;

        // Owner death clears every slot with no hit pulse
        tank_exit = 5'b00000;
        tick();
        check("dead_exit", 32'(bullet_exit), 32'd0);
        check("dead_hit", 32'(hit_tank), 32'd0);
        tank_exit = 5'b01000;

        // Upward spawn clamped to Y_MIN then killed
        set_tank(3, 100, 2);
        tank_direction = 2'b00;
        wait_ready(100);
        fire();
        check("up_exit", 32'(bullet_exit), 32'd1);
        check("up_x", 32'(bullet_x[9:0]), 32'd114);
        check("up_y", 32'(bullet_y[9:0]), 32'd1);
        tick();
        check("up_kill", 32'(bullet_exit), 32'd0);

        // Leftward bullet clamps at X_MIN then dies
        set_tank(3, 10, 200);
        tank_direction = 2'b10;
        wait_ready(100);
        fire();
        check("left_x0", 32'(bullet_x[9:0]), 32'd7);
        tick();
        check("left_x1", 32'(bullet_x[9:0]), 32'd4);
        tick();
        check("left_x2", 32'(bullet_x[9:0]), 32'd3);
        check("left_alive", 32'(bullet_exit), 32'd1);
        tick();
        check("left_kill", 32'(bullet_exit), 32'd0);

        // Live foreign tank 4 in the path
        set_tank(3, 100, 200);
        set_tank(4, 300, 214);
        tank_direction = 2'b11;
        tank_exit = 5'b11000;
        wait_ready(100);
        fire();
        repeat (57) tick();
        check("tank_pre_x", 32'(bullet_x[9:0]), 32'd301);
        check("tank_pre_hit", 32'(hit_tank), 32'd0);
        tick();
        check("tank_kill", 32'(bullet_exit), 32'd0);
        check("tank_hit", 32'(hit_tank), 32'd16);
        tick();
        check("tank_hit_end", 32'(hit_tank), 32'd0);

        // Dead tank 4 is passed through
        tank_exit = 5'b01000;
        wait_ready(100);
        fire();
        repeat (60) tick();
        check("pass_x", 32'(bullet_x[9:0]), 32'd310);
        check("pass_exit", 32'(bullet_exit), 32'd1);
        check("pass_hit", 32'(hit_tank), 32'd0);
        tank_exit = 5'b00000;
        tick();
        tank_exit = 5'b01000;

        // Foreign bullet: dx=2 misses, dx=1/dy=1 kills
        wait_ready(100);
        fire();
        check("fb_spawn_x", 32'(bullet_x[9:0]), 32'd130);
        other_bullet_x[50 +: 10] = 10'd132;
        other_bullet_y[50 +: 10] = 10'd215;
        otherbullet_exit = 8'b0010_0000;
        tick();
        check("fb_miss_exit", 32'(bullet_exit), 32'd1);
        check("fb_miss_x", 32'(bullet_x[9:0]), 32'd133);
        tick();
        check("fb_kill_exit", 32'(bullet_exit), 32'd0);
        check("fb_kill_x", 32'(bullet_x[9:0]), 32'd133);
        check("fb_kill_hit", 32'(hit_tank), 32'd0);
        otherbullet_exit = 8'b0;

        // Asynchronous reset mid-flight
        wait_ready(100);
        fire();
        repeat (2) tick();
        check("pre_rst_x", 32'(bullet_x[9:0]), 32'd136);
        rst_n = 1'b0;
        #2;
        check("arst_exit", 32'(bullet_exit), 32'd0);
        check("arst_xy", 32'({bullet_x, bullet_y}), 32'd0);
        check("arst_dir_new", 32'({bullet_dir, bullet_new}), 32'd0);
        check("arst_ready", 32'(ready), 32'd0);
        tick();
        rst_n = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
